// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Two-requester (execute / load) writeback arbiter driving a single
//            register-file write port, with per-register pending tracking.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        AValid,
    output logic        AReady,
    input  logic [4:0]  ARW,
    input  logic [63:0] AData,
    input  logic        BValid,
    output logic        BReady,
    input  logic [4:0]  BRW,
    input  logic [63:0] BData,
    output logic        RegWr,
    output logic [4:0]  RW,
    output logic [63:0] BusW,
    output logic [31:0] Pending
);

    localparam int         c_STAMP_W  = 3;
    localparam logic [4:0] c_ZERO_REG = 5'd31;

    logic                 r_aFull;
    logic [4:0]           r_aRW;
    logic [63:0]          r_aData;
    logic [c_STAMP_W-1:0] r_aStamp;
    logic                 r_bFull;
    logic [4:0]           r_bRW;
    logic [63:0]          r_bData;
    logic [c_STAMP_W-1:0] r_bStamp;
    logic [c_STAMP_W-1:0] r_seq;
    logic                 r_ptrB;
    logic                 r_regWr;
    logic [4:0]           r_rw;
    logic [63:0]          r_busW;

    logic [c_STAMP_W-1:0] w_stampDiff;
    logic                 w_tie;
    logic                 w_aOlder;
    logic                 w_bothFull;
    logic                 w_grantA;
    logic                 w_grantB;
    logic                 w_aLoad;
    logic                 w_bLoad;

    // Stamps live at most two loads apart, so a wrapped difference orders them.
    assign w_stampDiff = r_aStamp - r_bStamp;
    assign w_tie       = (w_stampDiff == '0);
    assign w_aOlder    = w_stampDiff[c_STAMP_W-1];
    assign w_bothFull  = r_aFull & r_bFull;

    assign w_grantA = r_aFull & (~r_bFull | (~w_tie & w_aOlder) | (w_tie & ~r_ptrB));
    assign w_grantB = r_bFull & ~w_grantA;

    assign AReady = ~r_aFull | w_grantA;
    assign BReady = ~r_bFull | w_grantB;

    // Register 31 is hard zero: the handshake completes but nothing is kept.
    assign w_aLoad = AValid & AReady & (ARW != c_ZERO_REG);
    assign w_bLoad = BValid & BReady & (BRW != c_ZERO_REG);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_aFull  <= 1'b0;
            r_aRW    <= '0;
            r_aData  <= '0;
            r_aStamp <= '0;
        end else if (w_aLoad) begin
            r_aFull  <= 1'b1;
            r_aRW    <= ARW;
            r_aData  <= AData;
            r_aStamp <= r_seq;
        end else if (w_grantA) begin
            r_aFull  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bFull  <= 1'b0;
            r_bRW    <= '0;
            r_bData  <= '0;
            r_bStamp <= '0;
        end else if (w_bLoad) begin
            r_bFull  <= 1'b1;
            r_bRW    <= BRW;
            r_bData  <= BData;
            r_bStamp <= r_seq;
        end else if (w_grantB) begin
            r_bFull  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_seq  <= '0;
            r_ptrB <= 1'b0;
        end else begin
            if (w_aLoad | w_bLoad) begin
                r_seq <= r_seq + 1'b1;
            end
            // Only same-age contention moves the round-robin pointer.
            if (w_bothFull & w_tie) begin
                r_ptrB <= w_grantA;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_regWr <= 1'b0;
            r_rw    <= '0;
            r_busW  <= '0;
        end else if (w_grantA) begin
            r_regWr <= 1'b1;
            r_rw    <= r_aRW;
            r_busW  <= r_aData;
        end else if (w_grantB) begin
            r_regWr <= 1'b1;
            r_rw    <= r_bRW;
            r_busW  <= r_bData;
        end else begin
            r_regWr <= 1'b0;
        end
    end

    assign RegWr = r_regWr;
    assign RW    = r_rw;
    assign BusW  = r_busW;

    always_comb begin
        Pending = '0;
        if (r_aFull) begin
            Pending = Pending | (32'd1 << r_aRW);
        end
        if (r_bFull) begin
            Pending = Pending | (32'd1 << r_bRW);
        end
        if (r_regWr) begin
            Pending = Pending | (32'd1 << r_rw);
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have ports: Clk in 1, clock, all state on posedge; Reset in 1, asynchronous active-high, clears all state.
REQ-002 SHALL have AValid in 1 (requester A, execute writeback, holds a write), AReady out 1 (A accepted this edge), ARW in 5 (destination register), AData in 64 (write data).
REQ-003 SHALL have BValid, BReady, BRW, BData with identical widths and meaning for requester B (load writeback).
REQ-004 SHALL have RegWr out 1, RW out 5, BusW out 64: register-file write port; the register file samples it on negedge Clk.
REQ-005 SHALL have Pending out 32: bit r high while any accepted, unwritten write targets register r.

Function
REQ-006 SHALL hold one-entry buffer per requester: full flag, 5-bit RW, 64-bit data, age stamp.
REQ-007 SHALL transfer on posedge when xValid && xReady; xReady = buffer empty OR buffer granted this cycle; xReady SHALL NOT depend on xValid.
REQ-008 SHALL accept requests with RW = 31 as a handshake but discard them: no buffering, no write, no Pending bit; register 31 reads as zero and is never written.
REQ-009 SHALL choose the grant combinationally from buffer state only: none full -> no grant; one full -> that one; both full -> older entry.
REQ-010 SHALL resolve both-full with equal age (same-edge accept) by round-robin pointer; pointer resets to A and toggles to the non-granted side after each such tie; other grants leave it unchanged.
REQ-011 SHALL, on the posedge a buffer is granted, load RW/BusW from it, set RegWr = 1, and clear the buffer unless refilled at that edge.
REQ-012 SHALL deassert RegWr on the next posedge when no grant exists; RW/BusW hold their last value while RegWr = 0.
REQ-013 Latency: accept at edge N -> RegWr high from edge N+1 (uncontested) -> written at negedge within cycle N+1.
REQ-014 Throughput: one write per cycle total; an uncontested requester sustains one write per cycle via REQ-007.
REQ-015 SHALL preserve per-register order: two writes to one register SHALL reach the port in acceptance order.
REQ-016 Pending SHALL be the OR of decoded RW of each full buffer and of the output register while RegWr = 1; it is combinational from state.
REQ-017 Simultaneous accept on A and B to the same register SHALL both be written, in round-robin order; the last write wins.

Reset
REQ-018 Reset high SHALL immediately force: buffers empty, RegWr = 0, RW = 0, BusW = 0, Pending = 0, pointer = A, age stamps cleared.
REQ-019 Reset mid-operation SHALL discard buffered and in-flight writes; no RegWr pulse after Reset asserts.
REQ-020 After Reset falls, AReady = BReady = 1 before the first posedge.

Verification
REQ-021 A only, ARW=5 AData=0x11 at edge 1 -> RegWr=1 RW=5 BusW=0x11 after edge 2; Pending[5]=1 from edge 1 until RegWr falls.
REQ-022 A (ARW=3, 0xAA) and B (BRW=3, 0xBB) same edge after reset -> A written first, then B; register 3 ends 0xBB; next tie grants B first.
REQ-023 B accepted edge 1 (RW=7), A accepted edge 2 (RW=8), both held -> RW=7 then RW=8; AReady=0 while A buffer waits.
REQ-024 ARW=31 AData=0xFF accepted -> AReady=1, RegWr stays 0, Pending stays 0.
REQ-025 A streams RW=1,2,3,4 on consecutive edges, B idle -> RegWr high four consecutive cycles, AReady never low.
REQ-026 Both buffers full, Reset asserted between edges -> RegWr=0 and Pending=0 at once; no write after release until new requests.
